sys_reset_ctrl: RTL and testbench

//  Board-level reset and clock-enable sequencer for the f8 system on iCEBreaker.

---
 rtl/f8_sysctl_pkg.sv | 15 +
 rtl/btn_debounce.sv | 51 +++++
 rtl/sys_reset_ctrl.sv | 149 ++++++++++++++
 tb/tb_sys_reset_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f8_sysctl_pkg.sv
// Shared types and constants for the f8 board-level reset/clock-enable sequencer.
//   sysctl_state_t : sequencer FSM state; the encoding is visible on the debug LEDs
//   RESET_COUNT_W  : width of the saturating reset counter
package f8_sysctl_pkg;

  typedef enum logic [1:0] {
    RESET   = 2'b00,
    HOLD    = 2'b01,
    RUN     = 2'b10,
    TRAPPED = 2'b11
  } sysctl_state_t;

  localparam int RESET_COUNT_W = 8;

endpackage

// File: rtl/btn_debounce.sv
// Reset-button conditioner: two-flop synchroniser followed by a debounce counter.
// The synchronised level must differ from the registered stable level for
// 2^BITS-1 consecutive CLK cycles before the stable level follows it.
// Ports:
//   CLK              in  board clock
//   power_on_reset_n in  asynchronous active-low reset
//   BTN_N            in  raw button, active low, asynchronous to CLK
//   pressed          out registered debounced press level (1 = held down)
module btn_debounce #(
  parameter int BITS = 16
) (
  input  logic CLK,
  input  logic power_on_reset_n,
  input  logic BTN_N,
  output logic pressed
);

  // The last count value before the stable level flips; the flip itself is
  // the 2^BITS-1'th consecutive disagreeing cycle.
  localparam logic [BITS-1:0] CNT_LAST = {BITS{1'b1}} - 1'b1;

  logic            sync1;
  logic            sync2;
  logic            stable;
  logic [BITS-1:0] cnt;

  // NOTE: synchroniser and stable level reset to 1 (button released), not 0,
  // so the system does not see a phantom press as it comes out of reset.
  always_ff @(posedge CLK or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      sync1 <= BTN_N;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pressed = ~stable;

endmodule

// File: rtl/sys_reset_ctrl.sv
// Board-level reset and clock-enable sequencer for the f8 system on iCEBreaker.
// Generates a single-CLK clock enable, holds the system in reset for a fixed
// number of enabled ticks after the button is released, and supervises the
// system trap flag with an optional automatic restart.
// Ports:
//   CLK              in  board clock (12 MHz)
//   power_on_reset_n in  asynchronous active-low reset
//   BTN_N            in  raw reset button, active low
//   trap             in  system trap flag, sampled only on clk_en
//   clk_en           out one-CLK-wide enable, once every DIV CLK cycles
//   sys_reset        out active-high system reset (registered)
//   state            out sequencer state for debug LEDs
//   reset_count      out resets since power-on, saturating
module sys_reset_ctrl
  import f8_sysctl_pkg::*;
#(
  parameter int DIV             = 4,
  parameter int DEBOUNCE_BITS   = 16,
  parameter int HOLD_CYCLES     = 16,
  parameter bit TRAP_RESTART    = 1'b1,
  parameter int TRAP_DELAY_BITS = 20
) (
  input  logic                     CLK,
  input  logic                     power_on_reset_n,
  input  logic                     BTN_N,
  input  logic                     trap,
  output logic                     clk_en,
  output logic                     sys_reset,
  output logic [1:0]               state,
  output logic [RESET_COUNT_W-1:0] reset_count
);

  localparam int DIV_W  = $clog2(DIV);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DIV_W-1:0]           DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [HOLD_W-1:0]          HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  // Restart fires on the 2^TRAP_DELAY_BITS-1'th cycle spent in TRAPPED.
  localparam logic [TRAP_DELAY_BITS-1:0] DELAY_LAST = {TRAP_DELAY_BITS{1'b1}} - 1'b1;

  logic                       pressed;
  logic [DIV_W-1:0]           div_cnt;
  logic [DIV_W-1:0]           div_next;
  sysctl_state_t              state_q;
  sysctl_state_t              state_d;
  logic [HOLD_W-1:0]          hold_cnt;
  logic [HOLD_W-1:0]          hold_d;
  logic [TRAP_DELAY_BITS-1:0] delay_cnt;
  logic [TRAP_DELAY_BITS-1:0] delay_d;
  logic                       count_inc;

  btn_debounce #(
    .BITS(DEBOUNCE_BITS)
  ) u_btn_debounce (
    .CLK              (CLK),
    .power_on_reset_n (power_on_reset_n),
    .BTN_N            (BTN_N),
    .pressed          (pressed)
  );

  // clk_en is registered from the next divider value so the pulse lines up
  // with div_cnt == DIV-1 without a combinational output.
  assign div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      div_cnt <= '0;
      clk_en  <= 1'b0;
    end else begin
      div_cnt <= div_next;
      clk_en  <= (div_next == DIV_LAST);
    end
  end

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_cnt;
    delay_d   = delay_cnt;
    count_inc = 1'b0;
    case (state_q)
      RESET: begin
        if (!pressed) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (pressed) begin
          state_d = RESET;
        end else if (clk_en) begin
          if (hold_cnt == HOLD_LAST) state_d = RUN;
          else                       hold_d  = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        // Button takes priority over a coincident trap.
        if (pressed) begin
          state_d   = RESET;
          count_inc = 1'b1;
        end else if (clk_en && trap) begin
          state_d = TRAPPED;
          delay_d = '0;
        end
      end
      TRAPPED: begin
        if (pressed) begin
          state_d   = RESET;
          count_inc = 1'b1;
        end else if (TRAP_RESTART) begin
          if (delay_cnt == DELAY_LAST) begin
            state_d   = HOLD;
            hold_d    = '0;
            count_inc = 1'b1;
          end else begin
            delay_d = delay_cnt + 1'b1;
          end
        end
      end
      default: state_d = RESET;
    endcase
  end

  always_ff @(posedge CLK or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      state_q     <= RESET;
      sys_reset   <= 1'b1;
      hold_cnt    <= '0;
      delay_cnt   <= '0;
      reset_count <= '0;
    end else begin
      state_q   <= state_d;
      // Registered from the next state so sys_reset changes on the same edge
      // as the state it belongs to.
      sys_reset <= (state_d == RESET) || (state_d == HOLD);
      hold_cnt  <= hold_d;
      delay_cnt <= delay_d;
      if (count_inc && (reset_count != '1)) begin
        reset_count <= reset_count + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_sys_reset_ctrl.sv
// Self-checking bench for sys_reset_ctrl. Two instances share all inputs:
// index 0 restarts automatically after a trap, index 1 stays trapped.
module tb_sys_reset_ctrl;

  localparam int DIV        = 4;
  localparam int DEB_RUN    = 7;   // 2^3-1 disagreeing cycles to register
  localparam int HOLD_TICKS = 4;
  localparam int TRAP_WAIT  = 15;  // 2^4-1 cycles spent in TRAPPED
  localparam logic [1:0] S_RESET = 2'b00, S_HOLD = 2'b01, S_RUN = 2'b10, S_TRAP = 2'b11;

  logic       CLK = 1'b0;
  logic       por_n;
  logic       btn_n;
  logic       trap;
  logic       clk_en_o    [2];
  logic       sys_reset_o [2];
  logic [1:0] state_o     [2];
  logic [7:0] count_o     [2];

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  sys_reset_ctrl #(
    .DIV(4), .DEBOUNCE_BITS(3), .HOLD_CYCLES(4), .TRAP_RESTART(1'b1), .TRAP_DELAY_BITS(4)
  ) dut (
    .CLK(CLK), .power_on_reset_n(por_n), .BTN_N(btn_n), .trap(trap),
    .clk_en(clk_en_o[0]), .sys_reset(sys_reset_o[0]), .state(state_o[0]), .reset_count(count_o[0])
  );

  sys_reset_ctrl #(
    .DIV(4), .DEBOUNCE_BITS(3), .HOLD_CYCLES(4), .TRAP_RESTART(1'b0), .TRAP_DELAY_BITS(4)
  ) dut_nr (
    .CLK(CLK), .power_on_reset_n(por_n), .BTN_N(btn_n), .trap(trap),
    .clk_en(clk_en_o[1]), .sys_reset(sys_reset_o[1]), .state(state_o[1]), .reset_count(count_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time is counted in CLK edges since reset release; the button is tracked
  // as a history of samples and a run length of disagreement.
  int       m_edges;
  bit       m_h1, m_h2, m_stable;
  int       m_run;
  logic [1:0] m_phase [2];
  int       m_ticks [2];
  int       m_age   [2];
  int       m_cnt   [2];

  task automatic model_reset();
    m_edges  = 0;
    m_h1     = 1'b1;
    m_h2     = 1'b1;
    m_stable = 1'b1;
    m_run    = 0;
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = S_RESET;
      m_ticks[i] = 0;
      m_age[i]   = 0;
      m_cnt[i]   = 0;
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic model_step();
    bit en, pressed, synced;
    en      = (m_edges % DIV == DIV - 1);
    m_edges = m_edges + 1;
    pressed = !m_stable;
    synced  = m_h2;
    m_h2    = m_h1;
    m_h1    = btn_n;
    if (synced != m_stable) begin
      m_run++;
      if (m_run == DEB_RUN) begin
        m_stable = synced;
        m_run    = 0;
      end
    end else begin
      m_run = 0;
    end
    for (int i = 0; i < 2; i++) begin
      case (m_phase[i])
        S_RESET: if (!pressed) begin m_phase[i] = S_HOLD; m_ticks[i] = 0; end
        S_HOLD: begin
          if (pressed) m_phase[i] = S_RESET;
          else if (en) begin
            m_ticks[i]++;
            if (m_ticks[i] == HOLD_TICKS) m_phase[i] = S_RUN;
          end
        end
        S_RUN: begin
          if (pressed) begin m_phase[i] = S_RESET; m_cnt[i] = sat_inc(m_cnt[i]); end
          else if (en && trap) begin m_phase[i] = S_TRAP; m_age[i] = 0; end
        end
        default: begin
          if (pressed) begin m_phase[i] = S_RESET; m_cnt[i] = sat_inc(m_cnt[i]); end
          else if (i == 0) begin
            m_age[i]++;
            if (m_age[i] == TRAP_WAIT) begin
              m_phase[i] = S_HOLD; m_ticks[i] = 0; m_cnt[i] = sat_inc(m_cnt[i]);
            end
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("model_state[%0d]", i), 32'(state_o[i]), 32'(m_phase[i]));
      check($sformatf("model_sys_reset[%0d]", i), 32'(sys_reset_o[i]),
            32'((m_phase[i] == S_RESET) || (m_phase[i] == S_HOLD)));
      check($sformatf("model_clk_en[%0d]", i), 32'(clk_en_o[i]), 32'(m_edges % DIV == DIV - 1));
      check($sformatf("model_count[%0d]", i), 32'(count_o[i]), 32'(m_cnt[i]));
    end
  endtask

  always @(posedge CLK or negedge por_n) begin
    if (!por_n) begin
      model_reset();
    end else begin
      model_step();
      #1;
      if (por_n) compare_all();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic reset_values(input string name);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_state[%0d]", name, i), 32'(state_o[i]), 32'(S_RESET));
      check($sformatf("%s_sys_reset[%0d]", name, i), 32'(sys_reset_o[i]), 32'd1);
      check($sformatf("%s_clk_en[%0d]", name, i), 32'(clk_en_o[i]), 32'd0);
      check($sformatf("%s_count[%0d]", name, i), 32'(count_o[i]), 32'd0);
    end
  endtask

  // Assert power-on reset mid-cycle, check it acts at once, then release.
  task automatic por_pulse(input string name);
    #2;
    por_n = 1'b0;
    #1;
    reset_values(name);
    @(negedge CLK);
    por_n = 1'b1;
  endtask

  task automatic wait_run(input string name, input bit both, input int budget);
    int  n;
    bit  ok;
    n  = 0;
    ok = (state_o[0] == S_RUN) && (!both || state_o[1] == S_RUN);
    while (!ok && n < budget) begin
      @(posedge CLK); #1;
      n++;
      ok = (state_o[0] == S_RUN) && (!both || state_o[1] == S_RUN);
    end
    check({name, "_reach_run"}, 32'(ok), 32'd1);
  endtask

  // Raise trap for exactly one clk_en tick; returns just after that edge.
  task automatic fire_trap(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge CLK);
      found = clk_en_o[0];
    end
    check({name, "_find_clk_en"}, 32'(found), 32'd1);
    trap = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    trap = 1'b0;
  endtask

  task automatic press_release(input int low_cycles);
    @(negedge CLK);
    btn_n = 1'b0;
    repeat (low_cycles) @(negedge CLK);
    btn_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int len;
    por_n = 1'b0;
    btn_n = 1'b1;
    trap  = 1'b0;
    repeat (3) @(negedge CLK);
    reset_values("por");
    por_n = 1'b1;

    // 1: startup sequence, hand-computed edge numbers after release
    for (int k = 1; k <= 16; k++) begin
      @(posedge CLK); #1;
      if (k == 1)            check("start_hold", 32'(state_o[0]), 32'(S_HOLD));
      if (k == 3 || k == 7)  check("start_clk_en_hi", 32'(clk_en_o[0]), 32'd1);
      if (k == 4)            check("start_clk_en_lo", 32'(clk_en_o[0]), 32'd0);
      if (k == 15) begin
        check("start_hold_last", 32'(state_o[0]), 32'(S_HOLD));
        check("start_sysrst_held", 32'(sys_reset_o[0]), 32'd1);
      end
      if (k == 16) begin
        check("start_run", 32'(state_o[0]), 32'(S_RUN));
        check("start_sysrst_rel", 32'(sys_reset_o[0]), 32'd0);
        check("start_count", 32'(count_o[0]), 32'd0);
      end
    end

    // 2: short glitch ignored, long press resets after 10 edges
    press_release(3);
    repeat (20) @(posedge CLK);
    #1 check("glitch_ignored", 32'(state_o[0]), 32'(S_RUN));
    @(negedge CLK);
    btn_n = 1'b0;
    repeat (9) @(posedge CLK);
    #1 check("press_edge9_run", 32'(state_o[0]), 32'(S_RUN));
    @(posedge CLK); #1;
    check("press_edge10_reset", 32'(state_o[0]), 32'(S_RESET));
    check("press_sysrst", 32'(sys_reset_o[0]), 32'd1);
    check("press_count", 32'(count_o[0]), 32'd1);
    repeat (2) @(negedge CLK);
    btn_n = 1'b1;
    wait_run("after_press", 1'b1, 200);

    // 3: trap with auto-restart after 15 CLK
    fire_trap("trap1");
    check("trap_state", 32'(state_o[0]), 32'(S_TRAP));
    check("trap_sysrst_low", 32'(sys_reset_o[0]), 32'd0);
    repeat (14) @(posedge CLK);
    #1 check("trap_still", 32'(state_o[0]), 32'(S_TRAP));
    @(posedge CLK); #1;
    check("trap_restart_hold", 32'(state_o[0]), 32'(S_HOLD));
    check("trap_restart_count", 32'(count_o[0]), 32'd2);
    wait_run("trap_restart", 1'b0, 100);

    // 4: no-restart instance stays trapped until a press
    repeat (1000) @(posedge CLK);
    #1 check("nr_trapped_1000", 32'(state_o[1]), 32'(S_TRAP));
    @(negedge CLK);
    btn_n = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    check("nr_press_state", 32'(state_o[1]), 32'(S_RESET));
    check("nr_press_count", 32'(count_o[1]), 32'd2);
    check("r_press_count", 32'(count_o[0]), 32'd3);
    repeat (2) @(negedge CLK);
    btn_n = 1'b1;
    wait_run("after_nr", 1'b1, 200);

    // 5: power-on reset mid-HOLD and mid-TRAPPED
    press_release(12);
    repeat (12) @(posedge CLK);
    #1 check("mid_hold_pre", 32'(state_o[0]), 32'(S_HOLD));
    por_pulse("mid_hold");
    wait_run("after_mid_hold", 1'b1, 100);
    fire_trap("trap2");
    repeat (5) @(posedge CLK);
    #1 check("mid_trap_pre", 32'(state_o[0]), 32'(S_TRAP));
    por_pulse("mid_trap");
    wait_run("after_mid_trap", 1'b1, 100);

    // randomized button activity and traps, checked against the model
    for (int ep = 0; ep < 40; ep++) begin
      @(negedge CLK);
      btn_n = 1'b0;
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 8) : $urandom_range(10, 24);
      for (int i = 0; i < len; i++) begin
        @(negedge CLK);
        trap = ($urandom_range(0, 5) == 0);
      end
      btn_n = 1'b1;
      len = $urandom_range(5, 70);
      for (int i = 0; i < len; i++) begin
        @(negedge CLK);
        trap = ($urandom_range(0, 5) == 0);
      end
    end
    trap = 1'b0;
    press_release(12);
    wait_run("after_random", 1'b1, 200);

    // 6: saturation of reset_count
    for (int n = 0; n < 300; n++) begin
      press_release($urandom_range(11, 14));
      wait_run("sat_loop", 1'b1, 200);
    end
    check("sat_count_r", 32'(count_o[0]), 32'd255);
    check("sat_count_nr", 32'(count_o[1]), 32'd255);

    // button and trap on the same clk_en edge: button wins
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
        @(negedge CLK);
        found = clk_en_o[0];
      end
      check("race_find_clk_en", 32'(found), 32'd1);
      repeat (3) @(negedge CLK);
      btn_n = 1'b0;
      repeat (9) @(negedge CLK);
      trap = 1'b1;
      @(posedge CLK); #1;
      check("race_button_wins", 32'(state_o[0]), 32'(S_RESET));
      check("race_button_wins_nr", 32'(state_o[1]), 32'(S_RESET));
      check("race_count_sat", 32'(count_o[0]), 32'd255);
      @(negedge CLK);
      trap = 1'b0;
      repeat (2) @(negedge CLK);
      btn_n = 1'b1;
      wait_run("after_race", 1'b1, 200);
    end

    repeat (5) @(posedge CLK);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
